// File: rtl/mux_sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_arbiter_pkg
//  Purpose  : Shared constants and types for the mux select arbiter.
//             SEL_A / SEL_B give the select polarity of the downstream 2:1 mux.
//             out_state_t encodes the one-entry output register occupancy.
//  Revision : 1.0  initial release
// ============================================================================
package mux_sel_arbiter_pkg;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

endpackage : mux_sel_arbiter_pkg
`default_nettype wire

// File: rtl/mux_sel_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_pick
//  Purpose  : Combinational winner selection between requesters A and B.
//             A lone valid requester always wins. On a tie the winner is the
//             requester that did not win last time (winner != last). Holding
//             last at SEL_B therefore yields fixed A-priority.
//  Ports    : a_valid, b_valid  - request lines
//             last              - id of the previous winner
//             enable            - output stage can accept a word this cycle
//             grant_a, grant_b  - one-hot grants (both low when !enable)
//             win_sel           - select of the granted requester (SEL_A idle)
//  Revision : 1.0  initial release
// ============================================================================
module mux_arb_pick
   import mux_sel_arbiter_pkg::*;
(
   input  logic a_valid,
   input  logic b_valid,
   input  logic last,
   input  logic enable,
   output logic grant_a,
   output logic grant_b,
   output logic win_sel
);

   logic tie_sel;

   always_comb begin
      tie_sel = ~last;
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (enable) begin
         if (a_valid && b_valid) begin
            grant_a = (tie_sel == SEL_A);
            grant_b = (tie_sel == SEL_B);
         end else begin
            grant_a = a_valid;
            grant_b = b_valid;
         end
      end
      win_sel = grant_b ? SEL_B : SEL_A;
   end

endmodule : mux_arb_pick
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_arbiter
//  Purpose  : Two-requester valid/ready arbiter feeding a one-entry registered
//             output stage that drives the 2:1 mux select (0=A, 1=B).
//             Back-to-back drain/reload with no bubble.
//  Config   : MUX_SEL_ARBITER_RR_EN defined  -> round-robin on ties
//             undefined                      -> fixed priority, A wins ties
//  Ports    : clk, rst_n (sync, active-low)
//             a_valid/a_data/a_ready, b_valid/b_data/b_ready - input streams
//             sel, out_valid, out_data, out_ready            - output stage
//  Revision : 1.0  initial release
// ============================================================================
module mux_sel_arbiter
   import mux_sel_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   out_state_t       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sel_q, sel_d;
   logic             last_v;
   logic             can_load;
   logic             grant_a, grant_b, win_sel;
   logic             load;

`ifdef MUX_SEL_ARBITER_RR_EN
   logic last_q, last_d;
   assign last_v = last_q;
`else
   // Pretending B always won last makes every tie go to A.
   assign last_v = SEL_B;
`endif

   assign out_valid = (state_q == FULL);
   // Gating with rst_n keeps both readies low during a reset cycle.
   assign can_load  = rst_n & (~out_valid | out_ready);

   mux_arb_pick u_pick (
      .a_valid (a_valid),
      .b_valid (b_valid),
      .last    (last_v),
      .enable  (can_load),
      .grant_a (grant_a),
      .grant_b (grant_b),
      .win_sel (win_sel)
   );

   assign load    = grant_a | grant_b;
   assign a_ready = grant_a;
   assign b_ready = grant_b;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
`ifdef MUX_SEL_ARBITER_RR_EN
      last_d  = last_q;
`endif
      if (load) begin
         state_d = FULL;
         data_d  = grant_b ? b_data : a_data;
         sel_d   = win_sel;
`ifdef MUX_SEL_ARBITER_RR_EN
         last_d  = win_sel;
`endif
      end else if ((state_q == FULL) && out_ready) begin
         // Drain only; data and sel keep their last value.
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         sel_q   <= SEL_A;
`ifdef MUX_SEL_ARBITER_RR_EN
         last_q  <= SEL_B;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
`ifdef MUX_SEL_ARBITER_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   assign out_data = data_q;
   assign sel      = sel_q;

endmodule : mux_sel_arbiter
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_sel_arbiter
//  Purpose  : Directed self-checking bench for mux_sel_arbiter. Stimulus
//             pushes expected {sel,data} words into a queue; a monitor pops
//             and compares on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_sel_arbiter;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             a_valid, b_valid, out_ready;
   logic [WIDTH-1:0] a_data, b_data;
   logic             a_ready, b_ready, sel, out_valid;
   logic [WIDTH-1:0] out_data;

   int n_vec = 0;
   int n_bad = 0;
   logic [WIDTH:0] exp_q[$];

   always #5 clk = ~clk;

   mux_sel_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_data    (b_data),
      .b_ready   (b_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic s, input logic [WIDTH-1:0] d);
      exp_q.push_back({s, d});
   endtask

   // Monitor: a word leaves the output stage at the next edge when valid & ready.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_unexpected: got sel=%0b data=0x%0h with empty queue", sel, out_data);
         end else begin
            logic [WIDTH:0] e;
            e = exp_q.pop_front();
            check("sb_data", {24'd0, out_data}, {24'd0, e[WIDTH-1:0]});
            check("sb_sel", {31'd0, sel}, {31'd0, e[WIDTH]});
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with both requesters valid.
      rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
      a_data = 8'h11; b_data = 8'h22;
      tick(); tick();
      check("rst_a_ready", {31'd0, a_ready}, 0);
      check("rst_b_ready", {31'd0, b_ready}, 0);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_data", {24'd0, out_data}, 0);
      check("rst_sel", {31'd0, sel}, 0);
      a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
      tick();

      // Single A word, then idle drains it.
      a_valid = 1'b1; a_data = 8'h3C; #1;
      check("single_a_ready", {31'd0, a_ready}, 1);
      push(1'b0, 8'h3C);
      tick();
      a_valid = 1'b0;
      check("single_valid", {31'd0, out_valid}, 1);
      check("single_data", {24'd0, out_data}, 32'h3C);
      tick();
      check("single_drained", {31'd0, out_valid}, 0);

      // Fresh reset so the first tie goes to A.
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
`ifdef MUX_SEL_ARBITER_RR_EN
         check("tie_b_ready", {31'd0, b_ready}, (i % 2 == 1) ? 1 : 0);
         if (i % 2 == 1) push(1'b1, 8'h22);
         else            push(1'b0, 8'h11);
`else
         check("tie_b_ready", {31'd0, b_ready}, 0);
         push(1'b0, 8'h11);
`endif
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      tick();

      // Backpressure: 0x55 held while B waits, then B reloads with no bubble.
      a_valid = 1'b1; a_data = 8'h55;
      push(1'b0, 8'h55);
      tick();
      a_valid = 1'b0; out_ready = 1'b0; b_valid = 1'b1; b_data = 8'h66;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_b_ready", {31'd0, b_ready}, 0);
         check("bp_hold_data", {24'd0, out_data}, 32'h55);
         b_data = 8'h77 + 8'(i);  // ignored while ready is low
         tick();
      end
      b_data = 8'h66; out_ready = 1'b1; #1;
      check("bp_release_b_ready", {31'd0, b_ready}, 1);
      push(1'b1, 8'h66);
      tick();
      b_valid = 1'b0;
      check("bp_reload_valid", {31'd0, out_valid}, 1);
      check("bp_reload_data", {24'd0, out_data}, 32'h66);
      check("bp_reload_sel", {31'd0, sel}, 1);
      tick();

      // Reset mid-stream discards the held word.
      out_ready = 1'b0; a_valid = 1'b1; a_data = 8'hAA;
      tick();
      check("mid_full", {31'd0, out_valid}, 1);
      a_valid = 1'b1; b_valid = 1'b1; rst_n = 1'b0; #1;
      check("mid_rst_a_ready", {31'd0, a_ready}, 0);
      check("mid_rst_b_ready", {31'd0, b_ready}, 0);
      tick();
      check("mid_out_valid", {31'd0, out_valid}, 0);
      check("mid_out_data", {24'd0, out_data}, 0);
      check("mid_sel", {31'd0, sel}, 0);
      rst_n = 1'b1; out_ready = 1'b1; a_data = 8'h11; b_data = 8'h22; #1;
      check("post_rst_a_ready", {31'd0, a_ready}, 1);
      check("post_rst_b_ready", {31'd0, b_ready}, 0);
      push(1'b0, 8'h11);
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      tick(); tick();

      check("sb_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_mux_sel_arbiter
`default_nettype wire

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Two-requester arbitrating front end for the 2:1 select mux datapath. Picks one of two valid/ready input streams each cycle, drives the `sel` line with the existing polarity (sel=0 routes A, sel=1 routes B), and captures the routed word in a one-entry registered output stage with backpressure. It sits directly upstream of the mux consumer and produces the select plus registered result the downstream logic uses.

## Interface
- `WIDTH`, 8, data width of both inputs and the output.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  synchronous reset, active-low.
- `a_valid`  input  1  requester A has a word.
- `a_data`  input  WIDTH  requester A word.
- `a_ready`  output  1  A word accepted this cycle (transfer = a_valid & a_ready).
- `b_valid`  input  1  requester B has a word.
- `b_data`  input  WIDTH  requester B word.
- `b_ready`  output  1  B word accepted this cycle.
- `sel`  output  1  registered select of the last accepted word (0=A, 1=B).
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  WIDTH  registered routed word.
- `out_ready`  input  1  downstream accepts out_data.

## Operation
- Output stage states: EMPTY (out_valid=0), FULL (out_valid=1).
- `load = (!out_valid | out_ready) & (a_valid | b_valid)`.
- Winner chosen combinationally when load: only one valid -> that one; both valid -> per priority rule (see Configuration).
- On load: out_data <= winner data; sel <= winner id; out_valid <= 1; winner's ready high that cycle, loser's ready low.
- FULL & out_ready & no valid input -> EMPTY (out_valid <= 0); out_data and sel hold last value.
- FULL & !out_ready -> hold everything; a_ready = b_ready = 0.
- FULL & out_ready & input valid -> back-to-back: drain and reload same cycle, no bubble.
- a_ready/b_ready are combinational from out_valid, out_ready, valids and the priority pointer; never both high.
- `last` register (1 bit) records winner id of each load; used only for round-robin.
- Input data sampled only on the load edge; data changes while ready low are ignored.

## Timing
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, sel=0, last=1 (A wins first tie). a_ready/b_ready evaluate to 0 while rst_n=0.
- Latency: input transfer at edge N -> out_valid/out_data/sel visible after edge N.
- Throughput: one word per cycle while out_ready=1.
- Reset mid-operation: a held FULL word is discarded; no ready asserted during the reset cycle.
- Simultaneous out_ready and new load: downstream takes the old word, new word appears next cycle.

## Configuration
- `MUX_SEL_ARBITER_RR_EN` defined: round-robin on ties; winner = requester not equal to `last`. Continuous dual requests alternate A,B,A,B.
- Not defined: fixed priority, A always wins ties; `last` register removed; B starves under continuous A traffic.

## Structure
- Package `mux_sel_arbiter_pkg`: `SEL_A = 1'b0`, `SEL_B = 1'b1`, enum `out_state_t {EMPTY, FULL}`.
- One sub-module `mux_arb_pick`: combinational, inputs a_valid, b_valid, last, enable; outputs grant_a, grant_b, win_sel. RR/fixed selection lives here.

## Test plan
- Reset: hold rst_n=0 with a_valid=b_valid=1 -> a_ready=b_ready=0, out_valid=0, out_data=0, sel=0.
- Single A: a_valid=1, a_data=0x3C, out_ready=1 -> next cycle out_valid=1, out_data=0x3C, sel=0; then no valid -> out_valid=0.
- Tie with RR_EN: a_data=0x11, b_data=0x22 both valid 4 cycles, out_ready=1 -> out_data 0x11,0x22,0x11,0x22; sel 0,1,0,1. Without macro -> 0x11 four times, b_ready never high.
- Backpressure: FULL with 0x55, out_ready=0 for 3 cycles while b_valid=1 -> out_data stays 0x55, b_ready=0; out_ready=1 -> B word loaded next cycle with no bubble.
- Reset mid-stream: FULL with 0xAA, rst_n=0 one cycle -> out_valid=0, out_data=0, sel=0; tie next -> A wins.
